cnn_result_spi_tx: RTL and testbench

SPI master transmitter that returns the CNN lane result to the host over the same SPI link that loads pixels. Captures each `final_lane_result` on a `final_result_valid` pulse and serialises a framed packet: header byte, six result bytes, optional checksum byte. It drives SCLK, CS_n and MOSI itself. It sits after `CNN_TOP` in the `sys_clk` domain.

---
 rtl/cnn_spi_pkg.sv | 20 ++
 rtl/spi_phase_gen.sv | 36 +++
 rtl/cnn_result_spi_tx.sv | 193 +++++++++++++++++++
 tb/tb_cnn_result_spi_tx.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/cnn_spi_pkg.sv
// rtl/cnn_spi_pkg.sv - shared types and frame constants for the CNN result SPI transmitter
package cnn_spi_pkg;

  // Transmitter sequencing: serialise bits, close the last SCLK period, then enforce CS-high spacing
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_HOLD  = 2'd2,
    ST_GAP   = 2'd3
  } tx_state_e;

  localparam logic [7:0] SPI_FRAME_HDR    = 8'hA5;
  localparam int         SPI_RESULT_BYTES = 6;
  localparam int         SPI_RESULT_W     = 8 * SPI_RESULT_BYTES;

  // Frame length in bits: header + result bytes, with or without the trailing XOR byte
  localparam int SPI_FRAME_BITS_CSUM   = 8 * (SPI_RESULT_BYTES + 2);
  localparam int SPI_FRAME_BITS_NOCSUM = 8 * (SPI_RESULT_BYTES + 1);

endpackage

// File: rtl/spi_phase_gen.sv
// rtl/spi_phase_gen.sv - SCLK half-period timer producing end-of-low and end-of-high ticks
module spi_phase_gen #(
  parameter int CLK_DIV = 4
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic restart_i,
  output logic lo_end_o,
  output logic hi_end_o
);

  localparam int              PW       = $clog2(CLK_DIV) + 1;
  localparam logic [PW-1:0]   CNT_LAST = PW'(CLK_DIV - 1);

  logic [PW-1:0] cnt_q;
  logic          hi_q;
  logic          last_cycle;

  assign last_cycle = (cnt_q == CNT_LAST);
  assign lo_end_o   = !restart_i && !hi_q && last_cycle;
  assign hi_end_o   = !restart_i &&  hi_q && last_cycle;

  // Count CLK_DIV cycles per half-period; restart parks the timer at the start of a low phase
  always_ff @(posedge clk_i) begin
    if (rst_i || restart_i) begin
      cnt_q <= '0;
      hi_q  <= 1'b0;
    end else if (last_cycle) begin
      cnt_q <= '0;
      hi_q  <= ~hi_q;
    end else begin
      cnt_q <= cnt_q + PW'(1);
    end
  end

endmodule

// File: rtl/cnn_result_spi_tx.sv
// rtl/cnn_result_spi_tx.sv - framed SPI mode-0 result transmitter; CNN_SPI_TX_CHECKSUM_EN adds an XOR byte
module cnn_result_spi_tx
  import cnn_spi_pkg::*;
#(
  parameter int CLK_DIV = 4,
  parameter int CS_GAP  = 8
) (
  input  logic                           sys_clk,
  input  logic                           sys_rst,
  input  logic                           final_result_valid,
  input  logic signed [SPI_RESULT_W-1:0] final_lane_result,
  input  logic                           overflow_clr,
  output logic                           tx_busy,
  output logic                           tx_done,
  output logic                           overflow,
  output logic                           spi_sclk,
  output logic                           spi_mosi,
  output logic                           spi_cs_n
);

`ifdef CNN_SPI_TX_CHECKSUM_EN
  localparam bit CSUM_EN = 1'b1;
`else
  localparam bit CSUM_EN = 1'b0;
`endif

  localparam int             NBITS    = CSUM_EN ? SPI_FRAME_BITS_CSUM : SPI_FRAME_BITS_NOCSUM;
  localparam int             BW       = $clog2(NBITS);
  localparam int             GW       = $clog2(CS_GAP) + 1;
  localparam logic [BW-1:0]  BIT_LAST = BW'(NBITS - 1);
  localparam logic [GW-1:0]  GAP_LAST = GW'(CS_GAP - 1);

  // Header first, result bytes MSB-first as raw slices, then the optional XOR of the result bytes
  function automatic logic [NBITS-1:0] build_frame(input logic [SPI_RESULT_W-1:0] r);
`ifdef CNN_SPI_TX_CHECKSUM_EN
    logic [7:0] csum;
    csum = '0;
    for (int i = 0; i < SPI_RESULT_BYTES; i++) begin
      csum = csum ^ r[8*i +: 8];
    end
    return {SPI_FRAME_HDR, r, csum};
`else
    return {SPI_FRAME_HDR, r};
`endif
  endfunction

  tx_state_e                 state_q;
  logic [NBITS-1:0]          shreg_q;
  logic [BW-1:0]             bit_q;
  logic [GW-1:0]             gap_q;
  logic                      sclk_q;
  logic                      cs_n_q;
  logic                      busy_q;
  logic                      done_q;

  logic                      pend_valid_q, pend_valid_d;
  logic [SPI_RESULT_W-1:0]   pend_data_q,  pend_data_d;
  logic                      ovf_q,        ovf_d;

  logic                      pg_restart;
  logic                      lo_end;
  logic                      hi_end;
  logic                      in_frame;
  logic                      gap_exit;
  logic                      consume;
  logic                      drop;

  // The phase timer only runs while SCLK periods are being generated (SHIFT and the trailing HOLD)
  assign pg_restart = !((state_q == ST_SHIFT) || (state_q == ST_HOLD));

  spi_phase_gen #(
    .CLK_DIV (CLK_DIV)
  ) u_phase (
    .clk_i     (sys_clk),
    .rst_i     (sys_rst),
    .restart_i (pg_restart),
    .lo_end_o  (lo_end),
    .hi_end_o  (hi_end)
  );

  assign in_frame = (state_q != ST_IDLE);
  assign gap_exit = (state_q == ST_GAP) && (gap_q == GAP_LAST);
  assign consume  = gap_exit && pend_valid_q;
  assign drop     = final_result_valid && in_frame && pend_valid_q && !consume;

  // Pending slot: fill while busy, free on GAP exit (refill in the same cycle allowed); drops are sticky
  always_comb begin
    pend_valid_d = pend_valid_q;
    pend_data_d  = pend_data_q;
    ovf_d        = ovf_q;
    if (consume) begin
      pend_valid_d = 1'b0;
    end
    if (final_result_valid && in_frame && (!pend_valid_q || consume)) begin
      pend_valid_d = 1'b1;
      pend_data_d  = final_lane_result;
    end
    if (drop) begin
      ovf_d = 1'b1;
    end else if (overflow_clr) begin
      ovf_d = 1'b0;
    end
  end

  // Register the pending buffer and overflow flag
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      pend_valid_q <= 1'b0;
      pend_data_q  <= '0;
      ovf_q        <= 1'b0;
    end else begin
      pend_valid_q <= pend_valid_d;
      pend_data_q  <= pend_data_d;
      ovf_q        <= ovf_d;
    end
  end

  // Frame sequencer: MOSI is the shift-register MSB, so shifting on the end of a high phase
  // changes data exactly at the start of the next low phase
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_q <= ST_IDLE;
      shreg_q <= '0;
      bit_q   <= '0;
      gap_q   <= '0;
      sclk_q  <= 1'b0;
      cs_n_q  <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        ST_IDLE: begin
          if (final_result_valid) begin
            shreg_q <= build_frame(final_lane_result);
            bit_q   <= '0;
            cs_n_q  <= 1'b0;
            busy_q  <= 1'b1;
            state_q <= ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          if (lo_end) begin
            sclk_q <= 1'b1;
          end
          if (hi_end) begin
            sclk_q  <= 1'b0;
            shreg_q <= {shreg_q[NBITS-2:0], 1'b0};
            if (bit_q == BIT_LAST) begin
              state_q <= ST_HOLD;
            end else begin
              bit_q <= bit_q + BW'(1);
            end
          end
        end
        ST_HOLD: begin
          if (lo_end) begin
            cs_n_q  <= 1'b1;
            done_q  <= 1'b1;
            gap_q   <= '0;
            state_q <= ST_GAP;
          end
        end
        ST_GAP: begin
          if (gap_q == GAP_LAST) begin
            if (pend_valid_q) begin
              shreg_q <= build_frame(pend_data_q);
              bit_q   <= '0;
              cs_n_q  <= 1'b0;
              state_q <= ST_SHIFT;
            end else begin
              busy_q  <= 1'b0;
              state_q <= ST_IDLE;
            end
          end else begin
            gap_q <= gap_q + GW'(1);
          end
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign tx_busy  = busy_q;
  assign tx_done  = done_q;
  assign overflow = ovf_q;
  assign spi_sclk = sclk_q;
  assign spi_mosi = shreg_q[NBITS-1];
  assign spi_cs_n = cs_n_q;

endmodule

// File: tb/tb_cnn_result_spi_tx.sv
// tb/tb_cnn_result_spi_tx.sv - scoreboard bench for cnn_result_spi_tx; honours CNN_SPI_TX_CHECKSUM_EN
module tb_cnn_result_spi_tx;

  localparam int CLK_DIV = 4;
  localparam int CS_GAP  = 8;
`ifdef CNN_SPI_TX_CHECKSUM_EN
  localparam int NB = 64;
`else
  localparam int NB = 56;
`endif
  localparam int CS_LOW  = NB * 2 * CLK_DIV + CLK_DIV;
  localparam int N_DONE  = 5;

  logic               sys_clk = 1'b0;
  logic               sys_rst;
  logic               final_result_valid;
  logic signed [47:0] final_lane_result;
  logic               overflow_clr;
  logic               tx_busy, tx_done, overflow, spi_sclk, spi_mosi, spi_cs_n;

  int          total = 0;
  int          bad   = 0;
  int          done_cnt = 0;
  int          last_gap = 0;
  logic [63:0] exp_q[$];

  always #5 sys_clk = ~sys_clk;

  cnn_result_spi_tx #(
    .CLK_DIV (CLK_DIV),
    .CS_GAP  (CS_GAP)
  ) dut (
    .sys_clk            (sys_clk),
    .sys_rst            (sys_rst),
    .final_result_valid (final_result_valid),
    .final_lane_result  (final_lane_result),
    .overflow_clr       (overflow_clr),
    .tx_busy            (tx_busy),
    .tx_done            (tx_done),
    .overflow           (overflow),
    .spi_sclk           (spi_sclk),
    .spi_mosi           (spi_mosi),
    .spi_cs_n           (spi_cs_n)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, expv);
    end
  endtask

  // Expected frame right-aligned in NB bits; checksum byte is hand-computed by the caller
  task automatic push(input logic [47:0] r, input logic [7:0] csum);
`ifdef CNN_SPI_TX_CHECKSUM_EN
    exp_q.push_back({8'hA5, r, csum});
`else
    exp_q.push_back({8'h00, 8'hA5, r});
    if (csum == 8'h00) exp_q[$] = exp_q[$];
`endif
  endtask

  // Called at posedge+1; leaves valid high for exactly one sampling edge
  task automatic send(input logic [47:0] r);
    final_lane_result  = r;
    final_result_valid = 1'b1;
    @(posedge sys_clk); #1;
    final_result_valid = 1'b0;
  endtask

  task automatic step(input int n);
    repeat (n) begin @(posedge sys_clk); #1; end
  endtask

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    do begin
      @(posedge sys_clk); #1;
      n++;
    end while ((tx_busy || exp_q.size() != 0) && n < 5000);
    check({tag, "_idle_in_time"}, 64'(n < 5000), 64'd1);
  endtask

  // Monitor: SPI sampler on rising SCLK, frame boundaries on CS_n, compares against the scoreboard
  initial begin : monitor
    bit          in_frame;
    bit          prev_sclk;
    bit          cs_rise;
    int          edges;
    int          low;
    int          hi_run;
    logic [63:0] rx;
    logic [63:0] expv;
    in_frame = 0; prev_sclk = 0; edges = 0; low = 0; hi_run = 0; rx = '0;
    forever begin
      @(negedge sys_clk);
      if (sys_rst) begin
        in_frame  = 0;
        prev_sclk = 0;
        hi_run    = 0;
      end else begin
        cs_rise = in_frame && spi_cs_n;
        if (tx_done || cs_rise) check("tx_done_at_cs_rise", 64'(tx_done), 64'(cs_rise));
        if (tx_done) done_cnt++;
        if (cs_rise) begin
          in_frame = 0;
          if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_frame: got %0h expected none", rx);
          end else begin
            expv = exp_q.pop_front();
            check("frame_data", rx, expv);
            check("sclk_rising_edges", 64'(edges), 64'(NB));
            check("cs_low_cycles", 64'(low), 64'(CS_LOW));
          end
        end
        if (!in_frame && !spi_cs_n) begin
          in_frame  = 1;
          last_gap  = hi_run;
          low       = 0;
          edges     = 0;
          rx        = '0;
          prev_sclk = 0;
        end
        if (in_frame) begin
          low++;
          if (spi_sclk && !prev_sclk) begin
            edges++;
            rx = {rx[62:0], spi_mosi};
          end
          prev_sclk = spi_sclk;
        end
        hi_run = spi_cs_n ? hi_run + 1 : 0;
      end
    end
  end

  initial begin : stimulus
    int idle_bad;
    int n;
    logic s0, s1;
    sys_rst            = 1'b1;
    final_result_valid = 1'b0;
    final_lane_result  = '0;
    overflow_clr       = 1'b0;
    repeat (3) @(posedge sys_clk);
    #1;
    check("reset_outputs", {58'd0, spi_cs_n, spi_sclk, spi_mosi, tx_busy, tx_done, overflow},
          64'b100000);
    sys_rst = 1'b0;

    idle_bad = 0;
    repeat (20) begin
      @(posedge sys_clk); #1;
      if (spi_cs_n !== 1'b1 || spi_sclk !== 1'b0 || tx_busy !== 1'b0) idle_bad++;
    end
    check("idle_20_cycles", 64'(idle_bad), 64'd0);

    // Basic frame: latency, first SCLK rise, busy-after-done spacing
    push(48'h0123_4567_89AB, 8'h22);
    send(48'h0123_4567_89AB);
    check("first_cycle_cs_busy_mosi", {61'd0, spi_cs_n, tx_busy, spi_mosi}, 64'b011);
    step(CLK_DIV - 1);
    s0 = spi_sclk;
    step(1);
    s1 = spi_sclk;
    check("first_sclk_rise_cycle", {62'd0, s0, s1}, 64'b01);
    n = 0;
    while (!tx_done && n < 3000) begin @(posedge sys_clk); #1; n++; end
    check("tx_done_seen", 64'(n < 3000), 64'd1);
    n = 0;
    while (tx_busy && n < 100) begin @(posedge sys_clk); #1; n++; end
    check("busy_fall_after_done", 64'(n), 64'(CS_GAP));
    wait_idle("frame_basic");

    // Negative result: raw two's-complement bytes
    push(48'hFFFF_FFFF_FFFE, 8'h01);
    send(48'hFFFF_FFFF_FFFE);
    wait_idle("frame_neg");

    // Three results during one frame: 1 sent, 2 pended, 3 dropped
    push(48'h0000_0000_0001, 8'h01);
    push(48'h0000_0000_0002, 8'h02);
    send(48'h0000_0000_0001);
    step(3);
    send(48'h0000_0000_0002);
    step(3);
    send(48'h0000_0000_0003);
    check("overflow_set_on_drop", 64'(overflow), 64'd1);
    wait_idle("frame_pending");
    check("gap_between_frames", 64'(last_gap >= CS_GAP), 64'd1);
    check("overflow_sticky", 64'(overflow), 64'd1);
    overflow_clr = 1'b1;
    step(1);
    overflow_clr = 1'b0;
    check("overflow_cleared", 64'(overflow), 64'd0);

    // Reset at the start of bit 20, then a clean frame
    send(48'h0000_0000_0BAD);
    step(20 * 2 * CLK_DIV);
    sys_rst = 1'b1;
    step(1);
    check("reset_mid_frame_outputs", {60'd0, spi_cs_n, spi_sclk, tx_done, tx_busy}, 64'b1000);
    sys_rst = 1'b0;
    step(2);
    push(48'h7E80_01FF_0042, 8'h42);
    send(48'h7E80_01FF_0042);
    wait_idle("frame_after_reset");

    step(5);
    check("scoreboard_empty", 64'(exp_q.size()), 64'd0);
    check("tx_done_count", 64'(done_cnt), 64'(N_DONE));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
